heartbeat_monitor: RTL and testbench
====================================

HEARTBEAT_MONITOR -- requirements
Module: heartbeat_monitor

Interface
REQ-001 Parameter NOM_PERIOD, default 29'd500000000, nominal heartbeat period in clk cycles (rising edge to rising edge).
REQ-002 Parameter TOL, default 29'd5000000, allowed +/- deviation from NOM_PERIOD in clk cycles.
REQ-003 Parameter LOCK_N, default 2, consecutive good periods needed to declare alive.
REQ-004 Port clk, input, 1, single system clock.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port hb_in, input, 1, heartbeat square wave from another block or domain, asynchronous to clk.
REQ-007 Port clr, input, 1, synchronous pulse that clears the fault counter.
REQ-008 Port alive, output, 1, high while in ALIVE.
REQ-009 Port fault, output, 1, high while in FAULT.
REQ-010 Port fault_led, output, 1, registered LED driver: fault OR (alive AND hb_sync).
REQ-011 Port last_period, output, 29, last measured period, captured at each rising edge.
REQ-012 Port fault_cnt, output, 8, saturating count of entries into FAULT.

Function
REQ-013 hb_in SHALL pass through a 2-flop synchronizer (hb_sync) followed by a registered rising-edge detector (hb_rise); the edge is seen 3 cycles after hb_in rises.
REQ-014 The period counter SHALL increment every cycle and saturate at 2^29-1.
REQ-015 On hb_rise the period counter SHALL load 1, and the cycle count SHALL be captured into last_period on the same edge.
REQ-016 A period is good iff NOM_PERIOD-TOL <= count <= NOM_PERIOD+TOL; the comparison SHALL be unsigned and 29 bits wide.
REQ-017 Timeout SHALL assert when the counter equals NOM_PERIOD+TOL+1 with no hb_rise in that cycle.
REQ-018 The FSM SHALL have the states IDLE, LOCK, ALIVE and FAULT.
REQ-019 IDLE -> LOCK on the first hb_rise; no period is judged on this edge; timeout in IDLE keeps IDLE.
REQ-020 LOCK: a good edge increments good_cnt; at good_cnt == LOCK_N -> ALIVE; a bad edge resets good_cnt to 0 and stays in LOCK; timeout -> FAULT.
REQ-021 ALIVE: a good edge stays in ALIVE; a bad edge or timeout -> FAULT.
REQ-022 FAULT: the next hb_rise -> LOCK with good_cnt = 0; that edge is not judged.
REQ-023 fault_cnt SHALL increment by 1 on each transition into FAULT and saturate at 255.
REQ-024 If clr and a FAULT entry occur in the same cycle, clr SHALL win and fault_cnt becomes 0.
REQ-025 hb_rise and timeout SHALL never coincide by construction; hb_rise takes precedence if both are evaluated.
REQ-026 All outputs SHALL be registered; alive and fault SHALL update one cycle after the triggering edge or timeout.

Reset
REQ-027 Reset assertion SHALL asynchronously force: state = IDLE, counter = 0, good_cnt = 0, synchronizer flops = 0, last_period = 0, fault_cnt = 0, alive = 0, fault = 0, fault_led = 0.
REQ-028 Reset asserted mid-measurement SHALL discard the partial period; after release, the first edge SHALL be treated as the IDLE edge.

Structure
REQ-029 A shared package/header hb_pkg SHALL hold the state encoding (2 bits) and the counter width constant (29).
REQ-030 One sub-module, sync_edge, SHALL implement the 2-flop synchronizer and rising-edge detector; the FSM, counters and compare logic remain in heartbeat_monitor.

Verification
REQ-031 The bench SHALL use NOM_PERIOD = 100, TOL = 10, LOCK_N = 2 for all scenarios below.
REQ-032 Lock: drive hb_in with period 100 -> alive = 1 one cycle after the 3rd rising edge as seen by hb_rise; last_period = 100.
REQ-033 Drift and boundary: drive periods 90, 110, 89 and 111 while ALIVE -> 90 and 110 stay ALIVE; 89 and 111 each enter FAULT, fault_cnt increments, last_period equals the bad value.
REQ-034 Loss: stop hb_in while ALIVE -> fault = 1 exactly 111 cycles after the last hb_rise; fault_cnt = 1; recovery edges return to ALIVE after LOCK_N good periods.
REQ-035 Saturation and clr: force 260 faults -> fault_cnt = 255; clr coinciding with a fault entry -> fault_cnt = 0.
REQ-036 Reset: assert rst_n low at cycle 50 of a period while ALIVE -> all outputs 0 immediately; after release, a period-100 input returns to ALIVE only after the IDLE edge plus 2 good periods.

Source files
------------

// File: rtl/hb_pkg.sv
// Shared definitions for the heartbeat monitor: counter widths and FSM state encoding.
package hb_pkg;

  localparam int unsigned CNT_W  = 29;
  localparam int unsigned FCNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK  = 2'd1,
    ALIVE = 2'd2,
    FAULT = 2'd3
  } hb_state_t;

  // Inclusive unsigned window test used to judge a measured period.
  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for the asynchronous heartbeat plus a registered rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic hb_in,
  output logic hb_sync,
  output logic hb_rise
);

  logic meta;
  logic sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta    <= 1'b0;
      hb_sync <= 1'b0;
      sync_d  <= 1'b0;
      hb_rise <= 1'b0;
    end else begin
      meta    <= hb_in;
      hb_sync <= meta;
      sync_d  <= hb_sync;
      hb_rise <= hb_sync & ~sync_d;
    end
  end

endmodule

// File: rtl/heartbeat_monitor.sv
// Measures the heartbeat period, locks after LOCK_N good periods and flags drift or loss.
module heartbeat_monitor
  import hb_pkg::*;
#(
  parameter logic [CNT_W-1:0] NOM_PERIOD = 29'd500000000,
  parameter logic [CNT_W-1:0] TOL        = 29'd5000000,
  parameter int unsigned      LOCK_N     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hb_in,
  input  logic              clr,
  output logic              alive,
  output logic              fault,
  output logic              fault_led,
  output logic [CNT_W-1:0]  last_period,
  output logic [FCNT_W-1:0] fault_cnt
);

  localparam int unsigned      GOOD_W = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] P_LO   = NOM_PERIOD - TOL;
  localparam logic [CNT_W-1:0] P_HI   = NOM_PERIOD + TOL;
  localparam logic [CNT_W-1:0] P_TMO  = P_HI + CNT_W'(1);

  logic              hb_sync;
  logic              hb_rise;
  logic [CNT_W-1:0]  cnt;
  logic              good_c;
  logic              timeout_c;
  hb_state_t         state;
  hb_state_t         state_nx;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_nx;
  logic              fault_entry_c;

  sync_edge u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .hb_in   (hb_in),
    .hb_sync (hb_sync),
    .hb_rise (hb_rise)
  );

  assign good_c        = in_window(cnt, P_LO, P_HI);
  assign timeout_c     = (cnt == P_TMO) && !hb_rise;
  assign fault_entry_c = (state_nx == FAULT) && (state != FAULT);

  // Period counter restarts at 1 on each edge so the captured value is the full edge-to-edge span.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      last_period <= '0;
    end else if (hb_rise) begin
      cnt         <= CNT_W'(1);
      last_period <= cnt;
    end else if (cnt != '1) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      good_cnt <= '0;
    end else begin
      state    <= state_nx;
      good_cnt <= good_nx;
    end
  end

  // Edges take precedence over timeout; the first edge after IDLE or FAULT only restarts measurement.
  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    unique case (state)
      IDLE: begin
        if (hb_rise) begin
          state_nx = LOCK;
          good_nx  = '0;
        end
      end
      LOCK: begin
        if (hb_rise) begin
          if (!good_c) begin
            good_nx = '0;
          end else if (good_cnt == GOOD_W'(LOCK_N - 1)) begin
            state_nx = ALIVE;
            good_nx  = '0;
          end else begin
            good_nx = good_cnt + GOOD_W'(1);
          end
        end else if (timeout_c) begin
          state_nx = FAULT;
          good_nx  = '0;
        end
      end
      ALIVE: begin
        if (hb_rise ? !good_c : timeout_c) begin
          state_nx = FAULT;
        end
      end
      FAULT: begin
        if (hb_rise) begin
          state_nx = LOCK;
          good_nx  = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        good_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive     <= 1'b0;
      fault     <= 1'b0;
      fault_led <= 1'b0;
      fault_cnt <= '0;
    end else begin
      alive     <= (state_nx == ALIVE);
      fault     <= (state_nx == FAULT);
      fault_led <= fault | (alive & hb_sync);
      if (clr) begin
        fault_cnt <= '0;
      end else if (fault_entry_c && (fault_cnt != '1)) begin
        fault_cnt <= fault_cnt + FCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Directed bench for heartbeat_monitor with NOM_PERIOD=100, TOL=10, LOCK_N=2.
module tb_heartbeat_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hb_in;
  logic        clr;
  logic        alive;
  logic        fault;
  logic        fault_led;
  logic [28:0] last_period;
  logic [7:0]  fault_cnt;

  int total = 0;
  int bad   = 0;
  int since = 0;

  heartbeat_monitor #(
    .NOM_PERIOD (29'd100),
    .TOL        (29'd10),
    .LOCK_N     (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hb_in       (hb_in),
    .clr         (clr),
    .alive       (alive),
    .fault       (fault),
    .fault_led   (fault_led),
    .last_period (last_period),
    .fault_cnt   (fault_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    since++;
  endtask

  // Raise hb_in from low and wait until its edge has been consumed (4 edges later).
  task automatic rise4();
    hb_in = 1'b1;
    since = 0;
    repeat (4) tick();
  endtask

  // Next rising edge p cycles after the previous one; returns one cycle before the FSM reacts.
  task automatic gap3(input int p);
    hb_in = 1'b0;
    while (since < p) tick();
    hb_in = 1'b1;
    since = 0;
    repeat (3) tick();
  endtask

  task automatic gap(input int p);
    gap3(p);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    hb_in = 1'b0;
    clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_alive", 32'(alive), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_led", 32'(fault_led), 32'd0);
    chk("rst_last", 32'(last_period), 32'd0);
    chk("rst_fcnt", 32'(fault_cnt), 32'd0);
    repeat (5) tick();

    // Lock: IDLE edge, then two good periods
    rise4();
    chk("lock_e1_alive", 32'(alive), 32'd0);
    gap(100);
    chk("lock_e2_alive", 32'(alive), 32'd0);
    chk("lock_e2_last", 32'(last_period), 32'd100);
    gap3(100);
    chk("lock_e3_pre", 32'(alive), 32'd0);
    tick();
    chk("lock_e3_alive", 32'(alive), 32'd1);
    chk("lock_e3_last", 32'(last_period), 32'd100);
    tick();
    chk("lock_led", 32'(fault_led), 32'd1);

    // Drift boundaries
    gap(90);
    chk("d90_alive", 32'(alive), 32'd1);
    chk("d90_last", 32'(last_period), 32'd90);
    gap(110);
    chk("d110_alive", 32'(alive), 32'd1);
    chk("d110_last", 32'(last_period), 32'd110);
    gap(89);
    chk("d89_fault", 32'(fault), 32'd1);
    chk("d89_alive", 32'(alive), 32'd0);
    chk("d89_fcnt", 32'(fault_cnt), 32'd1);
    chk("d89_last", 32'(last_period), 32'd89);
    gap(100);
    chk("rel1_fault", 32'(fault), 32'd0);
    chk("rel1_alive", 32'(alive), 32'd0);
    gap(100);
    gap(100);
    chk("rel_alive", 32'(alive), 32'd1);
    gap(111);
    chk("d111_fault", 32'(fault), 32'd1);
    chk("d111_fcnt", 32'(fault_cnt), 32'd2);
    chk("d111_last", 32'(last_period), 32'd111);
    gap(100);
    gap(100);
    gap(100);
    chk("relock_alive", 32'(alive), 32'd1);

    // clr, then loss of heartbeat
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_fcnt", 32'(fault_cnt), 32'd0);
    hb_in = 1'b0;
    while (since < 114) tick();
    chk("loss_pre_fault", 32'(fault), 32'd0);
    chk("loss_pre_alive", 32'(alive), 32'd1);
    tick();
    chk("loss_fault", 32'(fault), 32'd1);
    chk("loss_alive", 32'(alive), 32'd0);
    chk("loss_fcnt", 32'(fault_cnt), 32'd1);
    chk("loss_last", 32'(last_period), 32'd100);
    repeat (20) tick();
    rise4();
    chk("rec_e1_fault", 32'(fault), 32'd0);
    chk("rec_e1_alive", 32'(alive), 32'd0);
    gap(100);
    chk("rec_e2_alive", 32'(alive), 32'd0);
    gap(100);
    chk("rec_alive", 32'(alive), 32'd1);

    // Saturation: 260 timeout faults, alternating with a restarting edge
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 1; i <= 260; i++) begin
      hb_in = 1'b0;
      while (since < 115) tick();
      if (i == 255) chk("sat255_fcnt", 32'(fault_cnt), 32'd255);
      rise4();
    end
    chk("sat260_fcnt", 32'(fault_cnt), 32'd255);
    chk("sat_state_lock", 32'(fault), 32'd0);

    // clr coinciding with a fault entry
    hb_in = 1'b0;
    while (since < 114) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clrhit_fault", 32'(fault), 32'd1);
    chk("clrhit_fcnt", 32'(fault_cnt), 32'd0);
    tick();
    chk("fault_led", 32'(fault_led), 32'd1);

    // Reset mid-period while ALIVE with a non-zero fault count
    rise4();
    gap(100);
    gap(100);
    chk("pre_rst_alive", 32'(alive), 32'd1);
    gap(89);
    chk("pre_rst_fcnt", 32'(fault_cnt), 32'd1);
    gap(100);
    gap(100);
    gap(100);
    chk("pre_rst_alive2", 32'(alive), 32'd1);
    hb_in = 1'b0;
    while (since < 50) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_alive", 32'(alive), 32'd0);
    chk("mid_rst_fault", 32'(fault), 32'd0);
    chk("mid_rst_led", 32'(fault_led), 32'd0);
    chk("mid_rst_last", 32'(last_period), 32'd0);
    chk("mid_rst_fcnt", 32'(fault_cnt), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    gap(100);
    chk("post_rst_e1", 32'(alive), 32'd0);
    gap(100);
    chk("post_rst_e2", 32'(alive), 32'd0);
    chk("post_rst_last", 32'(last_period), 32'd100);
    gap3(100);
    chk("post_rst_e3_pre", 32'(alive), 32'd0);
    tick();
    chk("post_rst_alive", 32'(alive), 32'd1);
    chk("post_rst_fault", 32'(fault), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
